// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and forwarding controller for the Osiris I 5-stage pipeline.
//
// Produces the stall/flush controls for the PC, IF/ID, ID/EX and EX/MEM
// registers and the EX-stage operand forwarding selects. A small FSM holds
// the pipeline flushed for INIT_FLUSH cycles after reset, and tracks data
// memory wait states, aborting a stuck access after MEM_TIMEOUT wait cycles.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_rs1Addr_ID/i_rs2Addr_ID   source registers of the instruction in ID
//   i_rs1Addr_EX/i_rs2Addr_EX   source registers of the instruction in EX
//   i_rd_EX, i_result_src_EX    EX destination / result source (2'b01 = load)
//   i_pc_src_EX                 branch or jump taken in EX
//   i_rd_MEM, i_reg_write_MEM   MEM destination and write enable
//   i_rd_WB,  i_reg_write_WB    WB destination and write enable
//   i_dmem_req_MEM, i_dmem_ack  data memory handshake
//   o_stall_*                   hold PC / IF/ID / ID/EX / EX/MEM
//   o_flush_*                   clear IF/ID / ID/EX / EX/MEM
//   o_fwd_a_EX, o_fwd_b_EX      operand select: 00 regfile, 10 MEM, 01 WB
//   o_mem_err                   sticky data memory timeout flag
module hazard_ctrl #(
    parameter int REG_WIDTH   = 4,
    parameter int INIT_FLUSH  = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_WIDTH-1:0] i_rs1Addr_ID,
    input  logic [REG_WIDTH-1:0] i_rs2Addr_ID,
    input  logic [REG_WIDTH-1:0] i_rs1Addr_EX,
    input  logic [REG_WIDTH-1:0] i_rs2Addr_EX,
    input  logic [REG_WIDTH-1:0] i_rd_EX,
    input  logic [1:0]           i_result_src_EX,
    input  logic                 i_pc_src_EX,
    input  logic [REG_WIDTH-1:0] i_rd_MEM,
    input  logic                 i_reg_write_MEM,
    input  logic [REG_WIDTH-1:0] i_rd_WB,
    input  logic                 i_reg_write_WB,
    input  logic                 i_dmem_req_MEM,
    input  logic                 i_dmem_ack,
    output logic                 o_stall_IF,
    output logic                 o_stall_ID,
    output logic                 o_stall_EX,
    output logic                 o_stall_MEM,
    output logic                 o_flush_ID,
    output logic                 o_flush_EX,
    output logic                 o_flush_MEM,
    output logic [1:0]           o_fwd_a_EX,
    output logic [1:0]           o_fwd_b_EX,
    output logic                 o_mem_err
);

    localparam int IW = (INIT_FLUSH > 1) ? $clog2(INIT_FLUSH) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   init_cnt_q, init_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;

    logic mw;        // memory still busy this cycle
    logic timeout;   // stuck access gets aborted this cycle
    logic load_use;

    assign mw       = i_dmem_req_MEM && !i_dmem_ack;
    assign timeout  = (state_q == S_MEM_WAIT) && mw && (wait_cnt_q == WW'(MEM_TIMEOUT));
    assign load_use = (i_result_src_EX == 2'b01) && (i_rd_EX != '0) &&
                      ((i_rd_EX == i_rs1Addr_ID) || (i_rd_EX == i_rs2Addr_ID));
    assign o_mem_err = mem_err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == IW'(INIT_FLUSH - 1)) begin
                    state_d    = S_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (mw) begin
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = WW'(1);
                end
            end
            S_MEM_WAIT: begin
                if (timeout) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else if (mw) begin
                    // Saturates at MEM_TIMEOUT because timeout fires there.
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_INIT;
                init_cnt_d = '0;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stall / flush outputs. The non-busy cycle of S_MEM_WAIT (ack) behaves
    // like S_RUN, so a branch still held in EX flushes on that cycle.
    always_comb begin
        o_stall_IF  = 1'b0;
        o_stall_ID  = 1'b0;
        o_stall_EX  = 1'b0;
        o_stall_MEM = 1'b0;
        o_flush_ID  = 1'b0;
        o_flush_EX  = 1'b0;
        o_flush_MEM = 1'b0;
        case (state_q)
            S_RUN, S_MEM_WAIT: begin
                if (timeout) begin
                    // Abort: drop the stuck access and clear the pipe.
                    o_flush_ID  = 1'b1;
                    o_flush_EX  = 1'b1;
                    o_flush_MEM = 1'b1;
                end else if (mw) begin
                    o_stall_IF  = 1'b1;
                    o_stall_ID  = 1'b1;
                    o_stall_EX  = 1'b1;
                    o_stall_MEM = 1'b1;
                end else if (i_pc_src_EX) begin
                    o_flush_ID  = 1'b1;
                    o_flush_EX  = 1'b1;
                end else if (load_use) begin
                    // One bubble: next cycle the load sits in MEM and forwards.
                    o_stall_IF  = 1'b1;
                    o_stall_ID  = 1'b1;
                    o_flush_EX  = 1'b1;
                end
            end
            default: begin
                o_stall_IF  = 1'b1;
                o_flush_ID  = 1'b1;
                o_flush_EX  = 1'b1;
                o_flush_MEM = 1'b1;
            end
        endcase
    end

    // Forwarding is purely combinational and independent of the FSM.
    always_comb begin
        o_fwd_a_EX = 2'b00;
        o_fwd_b_EX = 2'b00;
        if (i_reg_write_MEM && (i_rd_MEM != '0) && (i_rd_MEM == i_rs1Addr_EX))
            o_fwd_a_EX = 2'b10;
        else if (i_reg_write_WB && (i_rd_WB != '0) && (i_rd_WB == i_rs1Addr_EX))
            o_fwd_a_EX = 2'b01;
        if (i_reg_write_MEM && (i_rd_MEM != '0) && (i_rd_MEM == i_rs2Addr_EX))
            o_fwd_b_EX = 2'b10;
        else if (i_reg_write_WB && (i_rd_WB != '0) && (i_rd_WB == i_rs2Addr_EX))
            o_fwd_b_EX = 2'b01;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed and randomized checks of hazard_ctrl against a
// cycle-level reference model of the pipeline control rules.
module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int IF_N = 2;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] i_rs1Addr_ID, i_rs2Addr_ID, i_rs1Addr_EX, i_rs2Addr_EX;
    logic [RW-1:0] i_rd_EX, i_rd_MEM, i_rd_WB;
    logic [1:0]    i_result_src_EX;
    logic          i_pc_src_EX, i_reg_write_MEM, i_reg_write_WB;
    logic          i_dmem_req_MEM, i_dmem_ack;
    logic          o_stall_IF, o_stall_ID, o_stall_EX, o_stall_MEM;
    logic          o_flush_ID, o_flush_EX, o_flush_MEM;
    logic [1:0]    o_fwd_a_EX, o_fwd_b_EX;
    logic          o_mem_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_init_left;
    int   m_waited;
    logic m_err;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_WIDTH(RW), .INIT_FLUSH(IF_N), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rs1Addr_ID(i_rs1Addr_ID), .i_rs2Addr_ID(i_rs2Addr_ID),
        .i_rs1Addr_EX(i_rs1Addr_EX), .i_rs2Addr_EX(i_rs2Addr_EX),
        .i_rd_EX(i_rd_EX), .i_result_src_EX(i_result_src_EX),
        .i_pc_src_EX(i_pc_src_EX),
        .i_rd_MEM(i_rd_MEM), .i_reg_write_MEM(i_reg_write_MEM),
        .i_rd_WB(i_rd_WB), .i_reg_write_WB(i_reg_write_WB),
        .i_dmem_req_MEM(i_dmem_req_MEM), .i_dmem_ack(i_dmem_ack),
        .o_stall_IF(o_stall_IF), .o_stall_ID(o_stall_ID),
        .o_stall_EX(o_stall_EX), .o_stall_MEM(o_stall_MEM),
        .o_flush_ID(o_flush_ID), .o_flush_EX(o_flush_EX), .o_flush_MEM(o_flush_MEM),
        .o_fwd_a_EX(o_fwd_a_EX), .o_fwd_b_EX(o_fwd_b_EX),
        .o_mem_err(o_mem_err)
    );

    // {stall IF,ID,EX,MEM, flush ID,EX,MEM}
    wire [6:0] ctl = {o_stall_IF, o_stall_ID, o_stall_EX, o_stall_MEM,
                      o_flush_ID, o_flush_EX, o_flush_MEM};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Newest producer wins; x0 is never a forwarding source.
    function automatic logic [1:0] fwd(input logic [RW-1:0] rs);
        if (i_reg_write_MEM && i_rd_MEM != 0 && i_rd_MEM == rs) return 2'b10;
        if (i_reg_write_WB && i_rd_WB != 0 && i_rd_WB == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        i_rs1Addr_ID = 0; i_rs2Addr_ID = 0; i_rs1Addr_EX = 0; i_rs2Addr_EX = 0;
        i_rd_EX = 0; i_rd_MEM = 0; i_rd_WB = 0; i_result_src_EX = 2'b00;
        i_pc_src_EX = 0; i_reg_write_MEM = 0; i_reg_write_WB = 0;
        i_dmem_req_MEM = 0; i_dmem_ack = 0;
    endtask

    // Inputs are already driven (posedge+1). Predict, check at posedge+4,
    // then advance the model across the clock edge.
    task automatic cycle(input string tag);
        logic [6:0] ec;
        logic       mw, lu, nerr;
        mw   = i_dmem_req_MEM && !i_dmem_ack;
        lu   = (i_result_src_EX == 2'b01) && i_rd_EX != 0 &&
               (i_rd_EX == i_rs1Addr_ID || i_rd_EX == i_rs2Addr_ID);
        nerr = m_err;
        if (m_init_left > 0) begin
            ec = 7'b1000_111;
            m_init_left--;
        end else if (mw && m_waited == MT) begin
            ec = 7'b0000_111;           // already stalled MT cycles: abort
            nerr = 1'b1;
            m_waited = 0;
        end else if (mw) begin
            ec = 7'b1111_000;
            m_waited++;
        end else begin
            m_waited = 0;
            if (i_pc_src_EX)  ec = 7'b0000_110;
            else if (lu)      ec = 7'b1100_010;
            else              ec = 7'b0000_000;
        end
        #3;
        chk({tag, ".ctl"},  {1'b0, ctl}, {1'b0, ec});
        chk({tag, ".fwda"}, {6'b0, o_fwd_a_EX}, {6'b0, fwd(i_rs1Addr_EX)});
        chk({tag, ".fwdb"}, {6'b0, o_fwd_b_EX}, {6'b0, fwd(i_rs2Addr_EX)});
        chk({tag, ".err"},  {7'b0, o_mem_err}, {7'b0, m_err});
        m_err = nerr;
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        m_init_left = 0; m_waited = 0; m_err = 1'b0;

        // Reset: flushes + PC hold, forwarding still live.
        i_reg_write_MEM = 1; i_rd_MEM = 7; i_rs1Addr_EX = 7;
        #12;
        chk("rst.ctl",  {1'b0, ctl}, 8'b0100_0111);
        chk("rst.err",  {7'b0, o_mem_err}, 8'd0);
        chk("rst.fwda", {6'b0, o_fwd_a_EX}, 8'b10);
        idle_inputs();

        @(posedge clk); #1;
        rst_n = 1'b1;
        m_init_left = IF_N; m_waited = 0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) cycle("init");

        // Forwarding: MEM beats WB, then WB, then x0 suppressed.
        i_rd_MEM = 5; i_rd_WB = 5; i_reg_write_MEM = 1; i_reg_write_WB = 1;
        i_rs1Addr_EX = 5; i_rs2Addr_EX = 5;
        cycle("fwd_mem");
        chk("fwd_mem.const", {6'b0, o_fwd_a_EX}, 8'b10);
        i_reg_write_MEM = 0;  cycle("fwd_wb");
        i_reg_write_MEM = 1; i_rd_MEM = 0; i_rd_WB = 0; i_rs1Addr_EX = 0; i_rs2Addr_EX = 0;
        cycle("fwd_x0");
        idle_inputs();

        // Load-use bubble, then coincident branch wins.
        i_result_src_EX = 2'b01; i_rd_EX = 3; i_rs2Addr_ID = 3;
        cycle("lu");
        i_pc_src_EX = 1;  cycle("lu_br");
        idle_inputs(); cycle("idle");

        // Memory wait: 3 busy cycles then ack.
        i_dmem_req_MEM = 1;
        for (int i = 0; i < 3; i++) cycle("mw");
        i_dmem_ack = 1; cycle("mw_ack");
        idle_inputs(); cycle("idle");

        // Wait beats branch; branch flush shows on the ack cycle.
        i_dmem_req_MEM = 1; i_pc_src_EX = 1;
        for (int i = 0; i < 2; i++) cycle("mw_br");
        i_dmem_ack = 1; cycle("mw_br_ack");
        idle_inputs(); cycle("idle");

        // Timeout: ack never arrives.
        i_dmem_req_MEM = 1;
        for (int i = 0; i < MT + 1; i++) cycle("tmo");
        idle_inputs();
        for (int i = 0; i < 2; i++) cycle("tmo_sticky");
        chk("tmo.err_const", {7'b0, o_mem_err}, 8'd1);

        // Randomized traffic with small register numbers to force overlaps.
        for (int n = 0; n < 400; n++) begin
            i_rs1Addr_ID    = RW'($urandom_range(0, 3));
            i_rs2Addr_ID    = RW'($urandom_range(0, 3));
            i_rs1Addr_EX    = RW'($urandom_range(0, 3));
            i_rs2Addr_EX    = RW'($urandom_range(0, 3));
            i_rd_EX         = RW'($urandom_range(0, 3));
            i_rd_MEM        = RW'($urandom_range(0, 3));
            i_rd_WB         = RW'($urandom_range(0, 3));
            i_result_src_EX = 2'($urandom_range(0, 3));
            i_pc_src_EX     = ($urandom_range(0, 5) == 0);
            i_reg_write_MEM = 1'($urandom);
            i_reg_write_WB  = 1'($urandom);
            i_dmem_req_MEM  = ($urandom_range(0, 2) != 0);
            i_dmem_ack      = ($urandom_range(0, 4) == 0);
            cycle("rnd");
        end

        // Reset asserted in the middle of a wait state.
        idle_inputs();
        i_dmem_req_MEM = 1;
        for (int i = 0; i < 2; i++) cycle("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.ctl", {1'b0, ctl}, 8'b0100_0111);
        chk("midrst.err", {7'b0, o_mem_err}, 8'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_init_left = IF_N; m_waited = 0; m_err = 1'b0;
        for (int i = 0; i < 3; i++) cycle("reinit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the Osiris I 5-stage pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EX (i_clear) and EX/MEM registers, and the EX-stage operand forwarding muxes.
- Owns a state machine for post-reset pipeline flush and for data-memory wait states (req/ack), with a timeout counter.

Parameters:
REG_WIDTH, 4, register address width (RV32E, 16 registers)
INIT_FLUSH, 2, cycles of forced flush after reset release (min 1)
MEM_TIMEOUT, 15, max consecutive dmem wait cycles before abort (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
i_rs1Addr_ID  in  REG_WIDTH  rs1 of instruction in ID
i_rs2Addr_ID  in  REG_WIDTH  rs2 of instruction in ID
i_rs1Addr_EX  in  REG_WIDTH  rs1 in EX
i_rs2Addr_EX  in  REG_WIDTH  rs2 in EX
i_rd_EX  in  REG_WIDTH  destination in EX
i_result_src_EX  in  2  result source in EX; 2'b01 = load
i_pc_src_EX  in  1  branch/jump taken in EX
i_rd_MEM  in  REG_WIDTH  destination in MEM
i_reg_write_MEM  in  1  MEM writes register
i_rd_WB  in  REG_WIDTH  destination in WB
i_reg_write_WB  in  1  WB writes register
i_dmem_req_MEM  in  1  data memory access pending in MEM
i_dmem_ack  in  1  data memory completes this cycle
o_stall_IF  out  1  hold PC
o_stall_ID  out  1  hold IF/ID
o_stall_EX  out  1  hold ID/EX
o_stall_MEM  out  1  hold EX/MEM
o_flush_ID  out  1  clear IF/ID
o_flush_EX  out  1  clear ID/EX (to i_clear)
o_flush_MEM  out  1  clear EX/MEM
o_fwd_a_EX  out  2  operand A select: 00 regfile, 10 MEM, 01 WB
o_fwd_b_EX  out  2  operand B select, same encoding
o_mem_err  out  1  sticky dmem timeout flag

Behaviour:
- States: S_INIT, S_RUN, S_MEM_WAIT. Registered: state, init_cnt, wait_cnt, o_mem_err. All other outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous):
  - state=S_INIT, init_cnt=0, wait_cnt=0, o_mem_err=0.
  - Outputs during reset: o_flush_ID=1, o_flush_EX=1, o_flush_MEM=1, o_stall_IF=1, other stalls 0.
  - Forwarding stays live during reset.
- S_INIT:
  - Asserts o_stall_IF and all three flushes.
  - init_cnt increments each cycle; when init_cnt==INIT_FLUSH-1, next state is S_RUN.
  - Exactly INIT_FLUSH flushed cycles after rst_n rises.
- Forwarding (all states):
  - fwd_a=10 if i_reg_write_MEM && i_rd_MEM!=0 && i_rd_MEM==i_rs1Addr_EX.
  - Else fwd_a=01 if i_reg_write_WB && i_rd_WB!=0 && i_rd_WB==i_rs1Addr_EX.
  - Else 00. fwd_b is the same using rs2. MEM has priority over WB; x0 is never forwarded.
- Memory wait (highest priority in S_RUN/S_MEM_WAIT):
  - Stall condition: mw = i_dmem_req_MEM && !i_dmem_ack.
  - mw=1 → all four stalls=1, all flushes=0, and branch and load-use are ignored that cycle.
  - S_RUN with mw → S_MEM_WAIT, wait_cnt=1.
  - S_MEM_WAIT: ack → S_RUN, wait_cnt=0, no stall that cycle. Otherwise wait_cnt increments.
- Timeout: in S_MEM_WAIT with mw and wait_cnt==MEM_TIMEOUT:
  - o_mem_err set (sticky until reset).
  - Stalls=0; o_flush_ID, o_flush_EX, o_flush_MEM=1 this cycle.
  - Next state S_RUN, wait_cnt=0.
- Branch (S_RUN, !mw): i_pc_src_EX=1 → o_flush_ID=1, o_flush_EX=1, no stalls.
- Load-use (S_RUN, !mw, !i_pc_src_EX):
  - Condition: i_result_src_EX==2'b01 && i_rd_EX!=0 && (i_rd_EX==i_rs1Addr_ID || i_rd_EX==i_rs2Addr_ID).
  - Response: o_stall_IF=1, o_stall_ID=1, o_flush_EX=1. One bubble only, because the next cycle the load is in MEM.
- Priority order: reset > S_INIT > mem wait/timeout > branch > load-use > none.
  - Branch coincident with load-use resolves as a branch flush with no stall.
- Never assert stall and flush on the same stage register in one cycle.
- wait_cnt width is $clog2(MEM_TIMEOUT+1); it never wraps.

Test Plan:
- Reset then release with INIT_FLUSH=2 → flushes high for exactly 2 cycles after rst_n rises, then 0; assert rst_n low mid-S_MEM_WAIT → flushes immediately high, o_mem_err=0.
- Forwarding: i_rd_MEM=5, i_rd_WB=5, both reg_write=1, i_rs1Addr_EX=5 → fwd_a=10; clear MEM write → 01; all addresses 0 with writes set → 00.
- Load-use: i_result_src_EX=01, i_rd_EX=3, i_rs2Addr_ID=3 → stall_IF=1, stall_ID=1, flush_EX=1 for one cycle; same stimulus with i_pc_src_EX=1 → flush_ID=1, flush_EX=1, stalls 0.
- Memory wait: req=1 with ack low 3 cycles, then high → all stalls high exactly 3 cycles, none on the ack cycle, o_mem_err=0.
- Timeout: MEM_TIMEOUT=4, req=1, ack never → stalls on cycles 1–4, abort cycle with three flushes, o_mem_err=1 stays set until reset.
- Wait beats branch: i_pc_src_EX=1 during mw → flushes 0, stalls 1; branch flush appears on the ack cycle if i_pc_src_EX is still high.
